// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, size encodings and constants for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ICACHE_RD, S_LSU_RD, S_LSU_WR} state_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] IO_HI = 2'b11;
  function automatic logic [4:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_B ? 5'd1 : sz == SZ_H ? 5'd2 : 5'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM/IO port shared by icache and LSU; MEM_ARB_FAIR_EN alternates grants after LSU
module mem_arbiter #(
  parameter int LINE_BYTES = 4,
  parameter logic [1:0] IO_HI = mem_arb_pkg::IO_HI
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    icache_req,
  input  logic [31:0]             icache_addr,
  output logic                    icache_done,
  output logic [8*LINE_BYTES-1:0] icache_data,
  input  logic                    lsu_req,
  input  logic                    lsu_wr,
  input  logic [1:0]              lsu_size,
  input  logic [31:0]             lsu_addr,
  input  logic [31:0]             lsu_wdata,
  output logic [31:0]             lsu_rdata,
  output logic                    lsu_done,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);
  import mem_arb_pkg::*;
  localparam int IW = 8 * LINE_BYTES;
  localparam int BW = IW > 32 ? IW : 32;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [4:0] k_q, k_d, n_q, n_d, k_nxt;
  logic [31:0] base_q, base_d, mem_a_q, mem_a_d, a_nxt, wsh, lsu_rdata_q, lsu_rdata_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [IW-1:0] icache_data_q, icache_data_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic mem_wr_q, mem_wr_d, icache_done_q, icache_done_d, lsu_done_q, lsu_done_d, fair_q, fair_d;
  logic grant_lsu, grant_ic, stall_grant, stall_nxt, stall_cur;
  assign k_nxt = k_q + 5'd1;
  assign a_nxt = base_q + 32'(k_q) + 32'd1;
  assign wsh = lsu_wdata >> {k_nxt[1:0], 3'b000};
  assign stall_grant = lsu_addr[17:16] == IO_HI && io_buffer_full;
  assign stall_nxt = a_nxt[17:16] == IO_HI && io_buffer_full;
  assign stall_cur = mem_a_q[17:16] == IO_HI && io_buffer_full;
  assign grant_lsu = lsu_req && !(FAIR_EN && fair_q && icache_req && !clear);
  assign grant_ic = icache_req && !clear && !grant_lsu;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    n_d = n_q;
    base_d = base_q;
    buf_d = buf_q;
    mem_a_d = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d = 1'b0;
    icache_done_d = 1'b0;
    lsu_done_d = 1'b0;
    icache_data_d = icache_data_q;
    lsu_rdata_d = lsu_rdata_q;
    fair_d = fair_q;
    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          state_d = lsu_wr ? S_LSU_WR : S_LSU_RD;
          base_d = lsu_addr;
          mem_a_d = lsu_addr;
          n_d = size_bytes(lsu_size);
          k_d = '0;
          buf_d = '0;
          mem_dout_d = lsu_wdata[7:0];
          mem_wr_d = lsu_wr && !stall_grant;
          fair_d = 1'b0;
        end else if (grant_ic) begin
          state_d = S_ICACHE_RD;
          base_d = icache_addr;
          mem_a_d = icache_addr;
          n_d = 5'(LINE_BYTES);
          k_d = '0;
          buf_d = '0;
          fair_d = 1'b0;
        end
      end
      S_LSU_WR: begin
        // mem_wr_q low means the current byte is still stalled behind a full IO buffer
        if (!mem_wr_q) mem_wr_d = !stall_cur;
        else if (k_nxt == n_q) begin
          state_d = S_IDLE;
          k_d = '0;
          lsu_done_d = 1'b1;
          fair_d = 1'b1;
        end else begin
          k_d = k_nxt;
          mem_a_d = a_nxt;
          mem_dout_d = wsh[7:0];
          mem_wr_d = !stall_nxt;
        end
      end
      default: begin
        // k counts cycles in the read state; the byte for address k-1 arrives now
        k_d = k_nxt;
        if (k_q != 5'd0) buf_d = buf_q | (BW'(mem_din) << {k_q - 5'd1, 3'b000});
        if (k_nxt < n_q) mem_a_d = a_nxt;
        if (k_q == n_q) begin
          state_d = S_IDLE;
          k_d = '0;
          if (state_q == S_ICACHE_RD) begin
            icache_done_d = 1'b1;
            icache_data_d = buf_d[IW-1:0];
          end else begin
            lsu_done_d = 1'b1;
            lsu_rdata_d = buf_d[31:0];
            fair_d = 1'b1;
          end
        end
        if (state_q == S_ICACHE_RD && clear) begin
          state_d = S_IDLE;
          k_d = '0;
          icache_done_d = 1'b0;
          icache_data_d = icache_data_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      n_q <= '0;
      base_q <= '0;
      buf_q <= '0;
      mem_a_q <= '0;
      mem_dout_q <= '0;
      mem_wr_q <= 1'b0;
      icache_done_q <= 1'b0;
      lsu_done_q <= 1'b0;
      icache_data_q <= '0;
      lsu_rdata_q <= '0;
      fair_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      base_q <= base_d;
      buf_q <= buf_d;
      mem_a_q <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q <= mem_wr_d;
      icache_done_q <= icache_done_d;
      lsu_done_q <= lsu_done_d;
      icache_data_q <= icache_data_d;
      lsu_rdata_q <= lsu_rdata_d;
      fair_q <= fair_d;
    end
  end
  assign icache_done = icache_done_q;
  assign icache_data = icache_data_q;
  assign lsu_done = lsu_done_q;
  assign lsu_rdata = lsu_rdata_q;
  assign mem_a = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr = mem_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a byte memory model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, rdy, clear, icache_req, icache_done, lsu_req, lsu_wr, lsu_done, mem_wr, io_buffer_full;
  logic [31:0] icache_addr, icache_data, lsu_addr, lsu_wdata, lsu_rdata, mem_a;
  logic [1:0] lsu_size;
  logic [7:0] mem_din = 8'h00;
  logic [7:0] mem_dout;
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_wr[$];
  logic [32:0] exp_lsu[$];
  logic [31:0] exp_ic[$];
  logic [7:0] wmem [0:4095];
  bit wv [0:4095];
  logic [39:0] ew;
  logic [32:0] el;
  logic [31:0] ei;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_done(icache_done), .icache_data(icache_data),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_size(lsu_size), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h202: return 8'h77;
      32'h203: return 8'h66;
      32'hFFFF_FFFF: return 8'hAB;
      32'h0: return 8'hCD;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] peek(input logic [31:0] a);
    return wv[a[11:0]] ? wmem[a[11:0]] : init_byte(a);
  endfunction

  function automatic int nb(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  // byte memory: read data appears one cycle after the address, writes land at the edge
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= peek(mem_a);
      if (mem_wr) begin
        wmem[mem_a[11:0]] <= mem_dout;
        wv[mem_a[11:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor: sampled after inputs settle, counts only cycles the DUT is enabled
  always @(negedge clk) begin
    #1;
    if (rdy) begin
      if (mem_wr) begin
        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          chk("wr_addr_data", {24'h0, mem_a, mem_dout}, {24'h0, ew});
        end
      end
      if (icache_done) begin
        chk("ic_done_expected", 64'(exp_ic.size() != 0), 64'd1);
        if (exp_ic.size() != 0) begin
          ei = exp_ic.pop_front();
          chk("ic_data", 64'(icache_data), 64'(ei));
        end
      end
      if (lsu_done) begin
        chk("lsu_done_expected", 64'(exp_lsu.size() != 0), 64'd1);
        if (exp_lsu.size() != 0) begin
          el = exp_lsu.pop_front();
          if (el[32]) chk("lsu_rdata", 64'(lsu_rdata), 64'(el[31:0]));
        end
      end
    end
  end

  task automatic wait_done(input string tag, input bit ic, input int start, input int lat);
    int n;
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (!(ic ? icache_done : lsu_done) && n < start + 40);
    chk(tag, 64'(n), 64'(lat));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_a"}, 64'(mem_a), 64'd0);
    chk({tag, "_mem_dout"}, 64'(mem_dout), 64'd0);
    chk({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
    chk({tag, "_ic_done"}, 64'(icache_done), 64'd0);
    chk({tag, "_lsu_done"}, 64'(lsu_done), 64'd0);
    chk({tag, "_ic_data"}, 64'(icache_data), 64'd0);
    chk({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'd0);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int lat);
    lsu_wr = 1'b0;
    lsu_size = sz;
    lsu_addr = a;
    lsu_req = 1'b1;
    exp_lsu.push_back({1'b1, d});
    wait_done($sformatf("load_lat_%0h", a), 1'b0, 0, lat);
    lsu_req = 1'b0;
  endtask

  task automatic push_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nb(sz); i++) exp_wr.push_back({a + 32'(i), 8'(wd >> (8 * i))});
    exp_lsu.push_back({1'b0, 32'h0});
    lsu_wr = 1'b1;
    lsu_size = sz;
    lsu_addr = a;
    lsu_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    icache_req = 1'b0; icache_addr = '0;
    lsu_req = 1'b0; lsu_wr = 1'b0; lsu_size = '0; lsu_addr = '0; lsu_wdata = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    // 4-byte icache fill, done 6 cycles after grant
    icache_addr = 32'h100;
    icache_req = 1'b1;
    exp_ic.push_back(32'h4433_2211);
    wait_done("ic_fill_lat", 1'b1, 0, 6);
    icache_req = 1'b0;
    // halfword store, then loads of every size including address wrap
    push_store(2'd1, 32'h200, 32'hDEAD_BEEF);
    lsu_req = 1'b1;
    wait_done("store_h_lat", 1'b0, 0, 3);
    lsu_req = 1'b0;
    chk("byte_202_untouched", 64'(peek(32'h202)), 64'h77);
    do_load(2'd2, 32'h200, 32'h6677_BEEF, 6);
    do_load(2'd0, 32'h201, 32'h0000_00BE, 3);
    do_load(2'd3, 32'h100, 32'h4433_2211, 6);
    do_load(2'd1, 32'hFFFF_FFFF, 32'h0000_CDAB, 4);
    // contention: LSU wins first
    icache_addr = 32'h100;
    icache_req = 1'b1;
    lsu_wr = 1'b0; lsu_size = 2'd0; lsu_addr = 32'h100;
    lsu_req = 1'b1;
    exp_lsu.push_back({1'b1, 32'h11});
    exp_lsu.push_back({1'b1, 32'h11});
    exp_ic.push_back(32'h4433_2211);
    wait_done("arb_lsu_first", 1'b0, 0, 3);
    chk("arb_no_ic_yet", 64'(icache_done), 64'd0);
`ifdef MEM_ARB_FAIR_EN
    wait_done("fair_ic_next", 1'b1, 0, 6);
    icache_req = 1'b0;
    wait_done("fair_lsu_after", 1'b0, 0, 3);
    lsu_req = 1'b0;
`else
    wait_done("fixed_lsu_again", 1'b0, 0, 3);
    lsu_req = 1'b0;
    wait_done("fixed_ic_after", 1'b1, 0, 6);
    icache_req = 1'b0;
`endif
    // clear in the third cycle of a fill aborts it
    icache_addr = 32'h100;
    icache_req = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_no_done", 64'(icache_done), 64'd0);
    chk("clear_no_wr", 64'(mem_wr), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    icache_req = 1'b0;
    do_load(2'd0, 32'h203, 32'h66, 3);
    // IO write held off while the output buffer is full
    io_buffer_full = 1'b1;
    push_store(2'd0, 32'h0003_0000, 32'h5A);
    lsu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("io_stall_wr_%0d", i), 64'(mem_wr), 64'd0);
    end
    io_buffer_full = 1'b0;
    wait_done("io_stall_lat", 1'b0, 3, 5);
    lsu_req = 1'b0;
    io_buffer_full = 1'b1;
    push_store(2'd0, 32'h0002_0000, 32'h3C);
    lsu_req = 1'b1;
    wait_done("non_io_no_stall_lat", 1'b0, 0, 2);
    lsu_req = 1'b0;
    io_buffer_full = 1'b0;
    // rdy low freezes a word store mid-flight
    push_store(2'd2, 32'h300, 32'h0102_0304);
    lsu_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rdy_pre_a", 64'(mem_a), 64'h301);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_hold_a", 64'(mem_a), 64'h301);
    chk("rdy_hold_wr", 64'(mem_wr), 64'd1);
    @(negedge clk);
    chk("rdy_hold_a2", 64'(mem_a), 64'h301);
    rdy = 1'b1;
    wait_done("rdy_store_lat", 1'b0, 4, 7);
    lsu_req = 1'b0;
    do_load(2'd2, 32'h300, 32'h0102_0304, 6);
    // reset during an LSU read, request held throughout
    lsu_wr = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h100;
    lsu_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    exp_lsu.push_back({1'b1, 32'h4433_2211});
    @(negedge clk);
    chk("restart_byte0_a", 64'(mem_a), 64'h100);
    wait_done("restart_lat", 1'b0, 1, 6);
    lsu_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("lsu_queue_empty", 64'(exp_lsu.size()), 64'd0);
    chk("ic_queue_empty", 64'(exp_ic.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
